// File: rtl/rr_mux.sv
// N-channel arbitrating mux with a single registered output stage.
// Round-robin or fixed-priority grant selected by the RR parameter.
module rr_mux #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N*WIDTH-1:0]   i_data,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         o_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [$clog2(N)-1:0] o_sel
);

    localparam int SW = $clog2(N);

    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    sel_q;
    logic             valid_q;
    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    ptr_d;

    logic             load_en;
    logic             found;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [N-1:0]     gnt_oh;

    assign load_en = !valid_q || i_ready;

    // Search starts at ptr and wraps; fixed-priority mode always starts at 0.
    always_comb begin : p_grant
        int base;
        int idx;
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        gnt_oh   = '0;
        idx      = 0;
        base     = (RR != 0) ? int'(ptr_q) : 0;
        for (int off = 0; off < N; off++) begin
            idx = base + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && i_valid[idx]) begin
                found       = 1'b1;
                gnt_idx     = SW'(idx);
                gnt_data    = i_data[idx*WIDTH +: WIDTH];
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (RR != 0 && found) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);
        end
    end

    assign o_ready = (i_rst_n && load_en) ? gnt_oh : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (load_en) begin
            ptr_q <= ptr_d;
            if (found) begin
                data_q  <= gnt_data;
                sel_q   <= gnt_idx;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data  = data_q;
    assign o_sel   = sel_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: one round-robin and one fixed-priority
// instance share all stimulus.
module tb_rr_mux;

    localparam int WIDTH = 4;
    localparam int N     = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*WIDTH-1:0] data;
    logic [N-1:0]     valid;
    logic             ready;

    logic [N-1:0]     rr_ready,  fp_ready;
    logic [WIDTH-1:0] rr_data,   fp_data;
    logic             rr_valid,  fp_valid;
    logic [1:0]       rr_sel,    fp_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_mux #(.WIDTH(WIDTH), .N(N), .RR(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .o_ready(rr_ready), .o_data(rr_data), .o_valid(rr_valid),
        .i_ready(ready), .o_sel(rr_sel)
    );

    rr_mux #(.WIDTH(WIDTH), .N(N), .RR(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .o_ready(fp_ready), .o_data(fp_data), .o_valid(fp_valid),
        .i_ready(ready), .o_sel(fp_sel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int rr_seq[5]  = '{0, 1, 2, 3, 0};
    int alt_seq[5] = '{3, 1, 3, 1, 3};

    initial begin
        data  = {4'h3, 4'h2, 4'h1, 4'h0};
        rst_n = 1'b0;
        valid = 4'b1111;
        ready = 1'b1;

        // Reset held for two edges
        cyc();
        cyc();
        chk("rst_ready", 32'(rr_ready), 32'b0000);
        chk("rst_valid", 32'(rr_valid), 32'd0);
        chk("rst_data",  32'(rr_data),  32'd0);
        chk("rst_sel",   32'(rr_sel),   32'd0);
        chk("rst_fp_ready", 32'(fp_ready), 32'b0000);

        // Single channel 2
        rst_n = 1'b1;
        valid = 4'b0100;
        #1;
        chk("single_ready", 32'(rr_ready), 32'b0100);
        cyc();
        chk("single_valid", 32'(rr_valid), 32'd1);
        chk("single_data",  32'(rr_data),  32'h2);
        chk("single_sel",   32'(rr_sel),   32'd2);

        // Reset to bring ptr back to 0, then round-robin over all four
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_sel",   32'(rr_sel),   32'(rr_seq[i]));
            chk("rr_data",  32'(rr_data),  32'(rr_seq[i]));
            chk("rr_valid", 32'(rr_valid), 32'd1);
        end

        // Load channel 1, then stall for three cycles
        cyc();
        chk("bp_load_sel", 32'(rr_sel), 32'd1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_zero", 32'(rr_ready), 32'b0000);
            cyc();
            chk("bp_hold_data",  32'(rr_data),  32'h1);
            chk("bp_hold_sel",   32'(rr_sel),   32'd1);
            chk("bp_hold_valid", 32'(rr_valid), 32'd1);
        end
        ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr_ready), 32'b0100);
        cyc();
        chk("bp_release_sel", 32'(rr_sel), 32'd2);

        // Nothing offered: o_valid drops, payload and index hold
        valid = 4'b0000;
        cyc();
        chk("idle_valid", 32'(rr_valid), 32'd0);
        chk("idle_sel",   32'(rr_sel),   32'd2);
        chk("idle_data",  32'(rr_data),  32'h2);

        // Channels 1 and 3: fixed priority always picks 1, RR (ptr=3) alternates
        valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fp_ready", 32'(fp_ready), 32'b0010);
            chk("rr_alt_ready", 32'(rr_ready), (alt_seq[i] == 3) ? 32'b1000 : 32'b0010);
            cyc();
            chk("fp_sel", 32'(fp_sel), 32'd1);
            chk("rr_alt_sel", 32'(rr_sel), 32'(alt_seq[i]));
        end

        // Reset while a word is held under backpressure
        valid = 4'b0100;
        cyc();
        chk("mid_load_sel", 32'(rr_sel), 32'd2);
        ready = 1'b0;
        cyc();
        chk("mid_hold_valid", 32'(rr_valid), 32'd1);
        rst_n = 1'b0;
        ready = 1'b1;
        valid = 4'b1111;
        #1;
        chk("mid_rst_ready", 32'(rr_ready), 32'b0000);
        cyc();
        chk("mid_rst_valid", 32'(rr_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(rr_ready), 32'b0001);
        cyc();
        chk("post_rst_sel",   32'(rr_sel),   32'd0);
        chk("post_rst_valid", 32'(rr_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
